// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Purpose  : RV32I immediate generator; same-cycle immediate plus a registered
//            copy with valid and format-error flags for the execute stage.
// Revision : 1.0
// ============================================================================
module imm_gen (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_inst,
    input  logic [5:0]  i_format,
    input  logic        i_valid,
    output logic [31:0] o_immediate,
    output logic [31:0] o_imm_q,
    output logic        o_valid_q,
    output logic        o_fmt_err,
    output logic        o_fmt_err_q
);

    localparam int c_FMT_I = 1;
    localparam int c_FMT_S = 2;
    localparam int c_FMT_B = 3;
    localparam int c_FMT_U = 4;
    localparam int c_FMT_J = 5;

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_fmt_none;
    logic        w_fmt_multi;
    logic        w_fmt_err;
    logic [5:0]  w_sel;
    logic [31:0] w_imm;
    logic        w_unused_opcode;

    logic [31:0] w_imm_d;
    logic        w_valid_d;
    logic        w_fmt_err_d;
    logic [31:0] r_imm_q;
    logic        r_valid_q;
    logic        r_fmt_err_q;

    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'h000};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // Opcode field is deliberately ignored; the decoder supplies the format.
    assign w_unused_opcode = &{1'b0, i_inst[6:0]};

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign w_fmt_none  = ~|i_format;
    assign w_fmt_multi = |(i_format & (i_format - 6'd1));
    assign w_fmt_err   = w_fmt_none | w_fmt_multi;

    // Flat AND-OR mux; R-type and illegal selects contribute nothing.
    always_comb begin
        w_sel = i_format & {6{~w_fmt_err}};
        w_imm = ({32{w_sel[c_FMT_I]}} & w_imm_i)
              | ({32{w_sel[c_FMT_S]}} & w_imm_s)
              | ({32{w_sel[c_FMT_B]}} & w_imm_b)
              | ({32{w_sel[c_FMT_U]}} & w_imm_u)
              | ({32{w_sel[c_FMT_J]}} & w_imm_j);
    end

    assign o_immediate = w_imm;
    assign o_fmt_err   = w_fmt_err;

    always_comb begin
        w_imm_d     = r_imm_q;
        w_valid_d   = i_valid;
        w_fmt_err_d = 1'b0;
        if (i_valid) begin
            w_imm_d     = w_imm;
            w_fmt_err_d = w_fmt_err;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_imm_q     <= 32'h0000_0000;
            r_valid_q   <= 1'b0;
            r_fmt_err_q <= 1'b0;
        end else begin
            r_imm_q     <= w_imm_d;
            r_valid_q   <= w_valid_d;
            r_fmt_err_q <= w_fmt_err_d;
        end
    end

    assign o_imm_q     = r_imm_q;
    assign o_valid_q   = r_valid_q;
    assign o_fmt_err_q = r_fmt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen
// Purpose  : Self-checking bench for imm_gen against a bit-field reference.
// Revision : 1.0
// ============================================================================
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [5:0]  fmt;
    logic        valid;
    logic [31:0] immediate;
    logic [31:0] imm_q;
    logic        valid_q;
    logic        fmt_err;
    logic        fmt_err_q;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard of the registered outputs.
    logic [31:0] exp_imm_q;
    logic        exp_valid_q;
    logic        exp_err_q;

    imm_gen dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_inst      (inst),
        .i_format    (fmt),
        .i_valid     (valid),
        .o_immediate (immediate),
        .o_imm_q     (imm_q),
        .o_valid_q   (valid_q),
        .o_fmt_err   (fmt_err),
        .o_fmt_err_q (fmt_err_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_err(input logic [5:0] f);
        return $countones(f) != 1;
    endfunction

    // Reference: rebuild each signed offset as a narrow signed value, then widen.
    function automatic logic [31:0] ref_imm(input logic [31:0] x, input logic [5:0] f);
        logic signed [11:0] v12;
        logic signed [12:0] v13;
        logic signed [20:0] v21;
        logic signed [31:0] r;
        r = 0;
        if (ref_err(f)) return 32'h0;
        case (f)
            6'b000010: begin v12 = x[31:20]; r = v12; end
            6'b000100: begin v12 = {x[31:25], x[11:7]}; r = v12; end
            6'b001000: begin v13 = {x[31], x[7], x[30:25], x[11:8], 1'b0}; r = v13; end
            6'b010000: r = x & 32'hffff_f000;
            6'b100000: begin v21 = {x[31], x[19:12], x[20], x[30:21], 1'b0}; r = v21; end
            default:   r = 0;
        endcase
        return r;
    endfunction

    task automatic model_clock();
        if (!rst_n) begin
            exp_imm_q = 0; exp_valid_q = 0; exp_err_q = 0;
        end else begin
            exp_valid_q = valid;
            if (valid) begin
                exp_imm_q = ref_imm(inst, fmt);
                exp_err_q = ref_err(fmt);
            end else begin
                exp_err_q = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; inst = 32'hfff0_0093; fmt = 6'b000010;
        exp_imm_q = 0; exp_valid_q = 0; exp_err_q = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({imm_q, valid_q, fmt_err_q} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got imm_q=%h v=%b e=%b, want 0/0/0", imm_q, valid_q, fmt_err_q);
        end
        n_cmp++;
        if (immediate !== 32'hffff_ffff) begin
            n_fail++;
            $display("FAIL reset_comb_tracks: got %h, want ffffffff", immediate);
        end
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [31:0] vi [8] = '{32'hfff00093, 32'h00112223, 32'hfe208ee3, 32'h123450b7,
                                32'hffdff0ef, 32'h12345678, 32'hdeadbeef, 32'h00000033};
        logic [5:0]  vf [8] = '{6'b000010, 6'b000100, 6'b001000, 6'b010000,
                                6'b100000, 6'b000000, 6'b000110, 6'b000001};
        logic [31:0] vx [8] = '{32'hffffffff, 32'h00000004, 32'hfffffffc, 32'h12345000,
                                32'hfffffffc, 32'h0, 32'h0, 32'h0};
        logic        ve [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            inst = vi[i]; fmt = vf[i];
            #1;
            n_cmp++;
            if (immediate !== vx[i] || fmt_err !== ve[i]) begin
                n_fail++;
                $display("FAIL vector_%0d: got imm=%h err=%b, want imm=%h err=%b",
                         i, immediate, fmt_err, vx[i], ve[i]);
            end
        end
    endtask

    task automatic test_random_comb();
        logic [5:0] f;
        for (int i = 0; i < 300; i++) begin
            inst = $urandom;
            f = (i % 3 == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            fmt = f;
            #1;
            n_cmp++;
            if (immediate !== ref_imm(inst, fmt) || fmt_err !== ref_err(fmt)) begin
                n_fail++;
                $display("FAIL random_comb: inst=%h fmt=%b got imm=%h err=%b, want imm=%h err=%b",
                         inst, fmt, immediate, fmt_err, ref_imm(inst, fmt), ref_err(fmt));
            end
        end
    endtask

    task automatic test_pipeline();
        @(posedge clk); #1;
        inst = 32'hfff0_0093; fmt = 6'b000010; valid = 1'b1;
        model_clock();
        @(posedge clk); #1;
        n_cmp++;
        if (imm_q !== 32'hffff_ffff || valid_q !== 1'b1 || fmt_err_q !== 1'b0) begin
            n_fail++;
            $display("FAIL pipe_capture: got imm_q=%h v=%b e=%b, want ffffffff/1/0", imm_q, valid_q, fmt_err_q);
        end
        valid = 1'b0; inst = 32'h1234_5678; fmt = 6'b000100;
        model_clock();
        @(posedge clk); #1;
        n_cmp++;
        if (imm_q !== 32'hffff_ffff || valid_q !== 1'b0 || fmt_err_q !== 1'b0) begin
            n_fail++;
            $display("FAIL pipe_hold: got imm_q=%h v=%b e=%b, want ffffffff/0/0", imm_q, valid_q, fmt_err_q);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            inst  = $urandom;
            fmt   = (i % 4 == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            valid = ($urandom_range(0, 3) != 0);
            model_clock();
            @(posedge clk); #1;
            n_cmp++;
            if (imm_q !== exp_imm_q || valid_q !== exp_valid_q || fmt_err_q !== exp_err_q) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got imm_q=%h v=%b e=%b, want %h/%b/%b",
                         i, imm_q, valid_q, fmt_err_q, exp_imm_q, exp_valid_q, exp_err_q);
            end
        end
    endtask

    task automatic test_fmt_err_q();
        inst = 32'hdead_beef; fmt = 6'b000110; valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (fmt_err_q !== 1'b1 || imm_q !== 32'h0 || valid_q !== 1'b1) begin
            n_fail++;
            $display("FAIL fmt_err_q_set: got e=%b imm_q=%h v=%b, want 1/00000000/1", fmt_err_q, imm_q, valid_q);
        end
        valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (fmt_err_q !== 1'b0 || imm_q !== 32'h0) begin
            n_fail++;
            $display("FAIL fmt_err_q_clear: got e=%b imm_q=%h, want 0/00000000", fmt_err_q, imm_q);
        end
    endtask

    task automatic test_reset_midstream();
        inst = 32'h1234_50b7; fmt = 6'b010000; valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (imm_q !== 32'h1234_5000 || valid_q !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_preload: got imm_q=%h v=%b, want 12345000/1", imm_q, valid_q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imm_q !== 32'h0 || valid_q !== 1'b0 || fmt_err_q !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got imm_q=%h v=%b e=%b, want 0/0/0", imm_q, valid_q, fmt_err_q);
        end
        n_cmp++;
        if (immediate !== 32'h1234_5000) begin
            n_fail++;
            $display("FAIL mid_comb_tracks: got %h, want 12345000", immediate);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random_comb();
        test_pipeline();
        test_back_to_back();
        test_fmt_err_q();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/imm_gen.md
# imm_gen

Immediate generator for the RV32I decode stage. It extracts and sign-extends the instruction immediate selected by a one-hot format code from the decoder. It drives a same-cycle combinational immediate for the decode datapath, plus a registered copy with valid and format-error flags for the execute-stage pipeline register.

## Interface
Parameters: none. Widths are fixed by RV32I.

Ports:
- `i_clk`  in  1  — clock. Rising-edge active.
- `i_rst_n`  in  1  — reset. Asynchronous, active-low.
- `i_inst`  in  32  — raw instruction word.
- `i_format`  in  6  — one-hot format select:
  - [0] R, [1] I, [2] S, [3] B, [4] U, [5] J.
- `i_valid`  in  1  — qualifies `i_inst`/`i_format` for capture into the output register.
- `o_immediate`  out  32  — combinational immediate for the current inputs.
- `o_imm_q`  out  32  — registered immediate.
- `o_valid_q`  out  1  — registered `i_valid`.
- `o_fmt_err`  out  1  — combinational flag: `i_format` is not exactly one-hot.
- `o_fmt_err_q`  out  1  — registered `o_fmt_err`, qualified by `i_valid`.

## Operation
Immediate per format; s = `i_inst[31]`, replicated as sign extension:
- **R:** 32'h0000_0000.
- **I:** {20×s, inst[31:20]}.
- **S:** {20×s, inst[31:25], inst[11:7]}.
- **B:** {19×s, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}. Bit 0 is always 0.
- **U:** {inst[31:12], 12'h000}. No sign extension beyond bit 31.
- **J:** {11×s, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}. Bit 0 is always 0.

Format select and error handling:
- Selection is AND-OR over the one-hot bits. Priority logic is not permitted.
- `i_format` == 0 or more than one bit set:
  - `o_immediate` = 0.
  - `o_fmt_err` = 1.
- Any legal one-hot value: `o_fmt_err` = 0.
- Opcode bits [6:0] are ignored. Format comes only from `i_format`.
- No X propagation from unused instruction bits. Output depends only on the bits listed above.

Register update on each rising edge:
- `o_valid_q` ← `i_valid`.
- If `i_valid`=1:
  - `o_imm_q` ← `o_immediate`.
  - `o_fmt_err_q` ← `o_fmt_err`.
- If `i_valid`=0:
  - `o_imm_q` holds its value.
  - `o_fmt_err_q` ← 0.

## Timing
- `o_immediate` and `o_fmt_err`: purely combinational, zero-cycle latency. Settled within the same cycle the inputs change; no clock dependence.
- `o_imm_q`, `o_valid_q`, `o_fmt_err_q`:
  - Latency is 1 cycle.
  - Throughput is one instruction per cycle.
  - Back-to-back `i_valid` is supported with no bubbles.
- Reset values: `o_imm_q`=0, `o_valid_q`=0, `o_fmt_err_q`=0.
- Reset asserted mid-stream clears the registered outputs immediately, asynchronously, regardless of `i_valid`. Combinational outputs keep tracking the inputs during reset.
- First capture occurs on the first rising edge after `i_rst_n` deasserts with `i_valid`=1.
- No handshake or backpressure. The downstream stage must accept every `o_valid_q` pulse.

## Test plan
- **I-type:** `i_inst`=fff00093 (addi x1,x0,-1), `i_format`=000010 → `o_immediate`=ffffffff, `o_fmt_err`=0.
- **S-type and B-type:**
  - 00112223 (sw x1,4(x2)), format 000100 → 00000004.
  - fe208ee3 (beq -4), format 001000 → fffffffc.
- **U-type and J-type:**
  - 123450b7 (lui 0x12345), format 010000 → 12345000.
  - ffdff0ef (jal -4), format 100000 → fffffffc.
- **Illegal and R formats:**
  - `i_format`=000000 or 000110, any `i_inst` → `o_immediate`=0, `o_fmt_err`=1.
  - `i_format`=000001 → `o_immediate`=0, `o_fmt_err`=0.
- **Pipeline:**
  - Sequence: reset low, then release. `i_valid`=1 with the addi vector, then `i_valid`=0 for one cycle.
  - Required: `o_imm_q`=ffffffff and `o_valid_q`=1 one cycle later. On the next cycle `o_valid_q`=0 and `o_imm_q` still ffffffff.
- **Reset mid-operation:** assert `i_rst_n`=0 between clock edges while `o_imm_q`≠0 → `o_imm_q`, `o_valid_q` and `o_fmt_err_q` go to 0 immediately, without waiting for a clock edge.
